// File: rtl/cross_product_scheduler_pkg.sv
// rtl/cross_product_scheduler_pkg.sv - shared types and latencies for the cross-product datapath
package cross_product_scheduler_pkg;

   localparam int MULT_LATENCY          = 3;
   localparam int ADD_LATENCY           = 2;
   localparam int CROSS_PRODUCT_LATENCY = MULT_LATENCY + ADD_LATENCY;
   localparam int COORD_W               = 16;

   typedef logic signed [COORD_W-1:0]   p_coord;
   typedef logic signed [2*COORD_W-1:0] p_prod;

   typedef struct packed {
      p_coord x;
      p_coord y;
      p_coord z;
   } p_float3;

   typedef struct packed {
      p_prod yz;
      p_prod zy;
      p_prod zx;
      p_prod xz;
      p_prod xy;
      p_prod yx;
   } p_prod6;

   // Coordinates wrap to COORD_W bits; the full-width difference is only an intermediate.
   function automatic p_coord wrap_diff(input p_prod p, input p_prod q);
      p_prod d;
      d = p - q;
      return d[COORD_W-1:0];
   endfunction

endpackage

// File: rtl/cross_product.sv
// rtl/cross_product.sv - fixed-latency pipelined cross product, no valid or stall
module cross_product
   import cross_product_scheduler_pkg::*;
(
   input  logic    clk,
   input  p_float3 a,
   input  p_float3 b,
   output p_float3 c
);

   p_prod6  prod;
   p_float3 sum;
   p_prod6  mult_pipe [MULT_LATENCY];
   p_float3 add_pipe  [ADD_LATENCY];

   always_comb begin
      prod.yz = p_prod'(a.y) * p_prod'(b.z);
      prod.zy = p_prod'(a.z) * p_prod'(b.y);
      prod.zx = p_prod'(a.z) * p_prod'(b.x);
      prod.xz = p_prod'(a.x) * p_prod'(b.z);
      prod.xy = p_prod'(a.x) * p_prod'(b.y);
      prod.yx = p_prod'(a.y) * p_prod'(b.x);
   end

   always_comb begin
      sum.x = wrap_diff(mult_pipe[MULT_LATENCY-1].yz, mult_pipe[MULT_LATENCY-1].zy);
      sum.y = wrap_diff(mult_pipe[MULT_LATENCY-1].zx, mult_pipe[MULT_LATENCY-1].xz);
      sum.z = wrap_diff(mult_pipe[MULT_LATENCY-1].xy, mult_pipe[MULT_LATENCY-1].yx);
   end

   always_ff @(posedge clk) begin
      mult_pipe[0] <= prod;
      for (int i = 1; i < MULT_LATENCY; i++) mult_pipe[i] <= mult_pipe[i-1];
      add_pipe[0] <= sum;
      for (int i = 1; i < ADD_LATENCY; i++) add_pipe[i] <= add_pipe[i-1];
   end

   assign c = add_pipe[ADD_LATENCY-1];

endmodule

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter, first valid request at or after rr_ptr wins
module rr_arbiter #(
   parameter int N_REQ = 3
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [N_REQ-1:0]         req,
   input  logic                     en,
   output logic [N_REQ-1:0]         grant,
   output logic [$clog2(N_REQ)-1:0] grant_idx
);

   localparam int IDX_W = $clog2(N_REQ);

   logic [IDX_W-1:0] rr_ptr;
   logic             found;
   int               idx;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      idx       = 0;
      for (int i = 0; i < N_REQ; i++) begin
         idx = int'(rr_ptr) + i;
         if (idx >= N_REQ) idx = idx - N_REQ;
         if (en && !rst && !found && req[idx]) begin
            found      = 1'b1;
            grant[idx] = 1'b1;
            grant_idx  = IDX_W'(idx);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr <= '0;
      end else if (found) begin
         rr_ptr <= (grant_idx == IDX_W'(N_REQ-1)) ? '0 : grant_idx + 1'b1;
      end
   end

endmodule

// File: rtl/cross_product_scheduler.sv
// rtl/cross_product_scheduler.sv - shares one cross_product between requesters with an ID tag pipeline
module cross_product_scheduler
   import cross_product_scheduler_pkg::*;
#(
   parameter int N_REQ   = 3,
   parameter int LATENCY = CROSS_PRODUCT_LATENCY
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         issue_en,
   input  logic [N_REQ-1:0]             req_valid,
   output logic [N_REQ-1:0]             req_ready,
   input  p_float3                      req_a [N_REQ],
   input  p_float3                      req_b [N_REQ],
   output p_float3                      xp_a,
   output p_float3                      xp_b,
   input  p_float3                      xp_c,
   output logic                         res_valid,
   output logic [$clog2(N_REQ)-1:0]     res_id,
   output p_float3                      res_c,
   output logic [$clog2(LATENCY+2)-1:0] in_flight,
   output logic                         idle
);

   localparam int IDX_W = $clog2(N_REQ);

   logic [IDX_W-1:0] grant_idx;
   logic             hs;
   logic [LATENCY:0] tag_valid;
   logic [IDX_W-1:0] tag_id [LATENCY+1];

   rr_arbiter #(.N_REQ(N_REQ)) u_arb (
      .clk       (clk),
      .rst       (rst),
      .req       (req_valid),
      .en        (issue_en),
      .grant     (req_ready),
      .grant_idx (grant_idx)
   );

   // The arbiter only grants valid requesters, so any grant is a handshake.
   assign hs = |req_ready;

   // One tag stage per operand register plus one per datapath stage keeps ID aligned with xp_c.
   always_ff @(posedge clk) begin
      if (rst) begin
         tag_valid <= '0;
         for (int i = 0; i <= LATENCY; i++) tag_id[i] <= '0;
         xp_a      <= '0;
         xp_b      <= '0;
         in_flight <= '0;
      end else begin
         tag_valid <= {tag_valid[LATENCY-1:0], hs};
         tag_id[0] <= hs ? grant_idx : '0;
         for (int i = 1; i <= LATENCY; i++) tag_id[i] <= tag_id[i-1];
         if (hs) begin
            xp_a <= req_a[grant_idx];
            xp_b <= req_b[grant_idx];
         end
         case ({hs, res_valid})
            2'b10:   in_flight <= in_flight + 1'b1;
            2'b01:   in_flight <= in_flight - 1'b1;
            default: in_flight <= in_flight;
         endcase
      end
   end

   assign res_valid = tag_valid[LATENCY];
   assign res_id    = tag_id[LATENCY];
   assign res_c     = xp_c;
   assign idle      = (in_flight == '0) && !(|req_valid);

endmodule

// File: tb/tb_cross_product_scheduler.sv
// tb/tb_cross_product_scheduler.sv - scoreboard bench for cross_product_scheduler with a real cross_product
module tb_cross_product_scheduler;
   import cross_product_scheduler_pkg::*;

   localparam int N   = 3;
   localparam int LAT = CROSS_PRODUCT_LATENCY;
   localparam int NV  = 12;

   typedef struct {
      int      id;
      p_float3 c;
      int      cyc;
   } exp_t;

   logic                       clk = 1'b0;
   logic                       rst;
   logic                       issue_en;
   logic [N-1:0]               req_valid;
   logic [N-1:0]               req_ready;
   p_float3                    req_a [N];
   p_float3                    req_b [N];
   p_float3                    xp_a, xp_b, xp_c, res_c;
   logic                       res_valid;
   logic [$clog2(N)-1:0]       res_id;
   logic [$clog2(LAT+2)-1:0]   in_flight;
   logic                       idle;

   p_float3 ta [NV];
   p_float3 tb [NV];
   p_float3 tc [NV];
   exp_t    sb [$];
   int      n_cmp = 0;
   int      n_bad = 0;
   int      cyc = 0;
   int      vc = 0;
   int      exp_inf = 0;
   int      peak = 0;
   bit      hs_flag = 0;
   bit      prev_rv = 0;

   always #5 clk = ~clk;

   cross_product_scheduler #(.N_REQ(N), .LATENCY(LAT)) dut (
      .clk       (clk),
      .rst       (rst),
      .issue_en  (issue_en),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .xp_a      (xp_a),
      .xp_b      (xp_b),
      .xp_c      (xp_c),
      .res_valid (res_valid),
      .res_id    (res_id),
      .res_c     (res_c),
      .in_flight (in_flight),
      .idle      (idle)
   );

   cross_product u_xp (.clk(clk), .a(xp_a), .b(xp_b), .c(xp_c));

   function automatic p_float3 mk(input int x, input int y, input int z);
      p_float3 v;
      v.x = p_coord'(x);
      v.y = p_coord'(y);
      v.z = p_coord'(z);
      return v;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Called just after a negedge: drive inputs, check the grant, predict the result.
   task automatic drive(input logic [N-1:0] v, input logic en, input logic r, input logic [N-1:0] exp_rdy);
      int g;
      req_valid = v;
      issue_en  = en;
      rst       = r;
      for (int i = 0; i < N; i++) begin
         req_a[i] = ta[(vc + 4*i) % NV];
         req_b[i] = tb[(vc + 4*i) % NV];
      end
      #1;
      chk("req_ready", 64'(req_ready), 64'(exp_rdy));
      hs_flag = (exp_rdy != '0);
      if (exp_rdy != '0) begin
         g = 0;
         for (int i = 0; i < N; i++) if (exp_rdy[i]) g = i;
         sb.push_back('{id: g, c: tc[(vc + 4*g) % NV], cyc: cyc + 1 + LAT});
         vc++;
      end
      @(negedge clk);
      #1;
   endtask

   task automatic drain(input logic en);
      for (int k = 0; k < 40 && (sb.size() != 0 || in_flight != '0); k++) drive('0, en, 1'b0, '0);
      chk("drain_sb_empty", 64'(sb.size()), 64'd0);
      chk("drain_in_flight", 64'(in_flight), 64'd0);
   endtask

   // Monitor: samples 1 time unit after each rising edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         if (rst) begin
            sb.delete();
            exp_inf = 0;
         end else begin
            exp_inf = exp_inf + int'(hs_flag) - int'(prev_rv);
         end
         hs_flag = 0;
         chk("in_flight", 64'(in_flight), 64'(exp_inf));
         if (int'(in_flight) > peak) peak = int'(in_flight);
         if (res_valid === 1'b1) begin
            if (sb.size() == 0) begin
               chk("unexpected_res_valid", 64'(res_valid), 64'd0);
            end else begin
               e = sb.pop_front();
               chk("res_id", 64'(res_id), 64'(e.id));
               chk("res_c", 64'(res_c), 64'(e.c));
               chk("res_cycle", 64'(cyc), 64'(e.cyc));
            end
         end
         prev_rv = (res_valid === 1'b1) && !rst;
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout expected finish");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
      $fatal(1);
   end

   initial begin
      ta[0]  = mk(1, 0, 0);    tb[0]  = mk(0, 1, 0);  tc[0]  = mk(0, 0, 1);
      ta[1]  = mk(0, 1, 0);    tb[1]  = mk(0, 0, 1);  tc[1]  = mk(1, 0, 0);
      ta[2]  = mk(0, 0, 1);    tb[2]  = mk(1, 0, 0);  tc[2]  = mk(0, 1, 0);
      ta[3]  = mk(1, 2, 3);    tb[3]  = mk(4, 5, 6);  tc[3]  = mk(-3, 6, -3);
      ta[4]  = mk(2, 0, 0);    tb[4]  = mk(0, 3, 0);  tc[4]  = mk(0, 0, 6);
      ta[5]  = mk(1, 1, 0);    tb[5]  = mk(0, 1, 1);  tc[5]  = mk(1, -1, 1);
      ta[6]  = mk(3, -1, 2);   tb[6]  = mk(1, 4, -2); tc[6]  = mk(-6, 8, 13);
      ta[7]  = mk(0, 5, 0);    tb[7]  = mk(7, 0, 0);  tc[7]  = mk(0, 0, -35);
      ta[8]  = mk(2, 2, 2);    tb[8]  = mk(1, 2, 3);  tc[8]  = mk(2, -4, 2);
      ta[9]  = mk(-2, 1, 4);   tb[9]  = mk(3, 0, -1); tc[9]  = mk(-1, 10, -3);
      ta[10] = mk(5, 0, 0);    tb[10] = mk(5, 0, 0);  tc[10] = mk(0, 0, 0);
      ta[11] = mk(10, 20, 30); tb[11] = mk(-1, 0, 1); tc[11] = mk(20, -40, 20);

      rst       = 1'b1;
      issue_en  = 1'b1;
      req_valid = '0;
      for (int i = 0; i < N; i++) begin
         req_a[i] = '0;
         req_b[i] = '0;
      end
      repeat (3) @(negedge clk);
      #1;
      chk("reset_req_ready", 64'(req_ready), 64'd0);
      chk("reset_xp_a", 64'(xp_a), 64'd0);
      chk("reset_xp_b", 64'(xp_b), 64'd0);
      chk("reset_res_valid", 64'(res_valid), 64'd0);
      chk("reset_res_id", 64'(res_id), 64'd0);
      chk("reset_in_flight", 64'(in_flight), 64'd0);
      chk("reset_idle", 64'(idle), 64'd1);
      drive('0, 1'b1, 1'b0, '0);

      // Full contention: grants rotate 0,1,2 from a freshly reset pointer.
      peak = 0;
      for (int k = 0; k < 9; k++) drive(3'b111, 1'b1, 1'b0, 3'(3'b001 << (k % 3)));
      drain(1'b1);
      chk("contention_peak", 64'(peak), 64'(LAT + 1));

      // Single issue from requester 1.
      drive(3'b010, 1'b1, 1'b0, 3'b010);
      drain(1'b1);

      // Continuous requester 0: in_flight saturates while issue and retire overlap.
      peak = 0;
      for (int k = 0; k < 10; k++) drive(3'b001, 1'b1, 1'b0, 3'b001);
      chk("saturate_in_flight", 64'(in_flight), 64'(LAT + 1));
      chk("saturate_peak", 64'(peak), 64'(LAT + 1));
      drain(1'b1);

      // issue_en drop after four issues.
      for (int k = 0; k < 4; k++) drive(3'b001, 1'b1, 1'b0, 3'b001);
      drive(3'b001, 1'b0, 1'b0, 3'b000);
      drain(1'b0);
      chk("idle_after_drop", 64'(idle), 64'd1);

      // Reset with five in flight: those results are discarded, pointer returns to 0.
      drive(3'b111, 1'b1, 1'b0, 3'b010);
      drive(3'b111, 1'b1, 1'b0, 3'b100);
      drive(3'b111, 1'b1, 1'b0, 3'b001);
      drive(3'b111, 1'b1, 1'b0, 3'b010);
      drive(3'b001, 1'b1, 1'b0, 3'b001);
      chk("pre_reset_in_flight", 64'(in_flight), 64'd5);
      drive(3'b111, 1'b1, 1'b1, 3'b000);
      chk("post_reset_in_flight", 64'(in_flight), 64'd0);
      drive(3'b111, 1'b1, 1'b0, 3'b001);
      drain(1'b1);

      // Fairness: requester 2 pulses while 0 is held, and wins immediately.
      drive(3'b001, 1'b1, 1'b0, 3'b001);
      drive(3'b001, 1'b1, 1'b0, 3'b001);
      drive(3'b101, 1'b1, 1'b0, 3'b100);
      drive(3'b001, 1'b1, 1'b0, 3'b001);
      drain(1'b1);

      chk("final_sb_empty", 64'(sb.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
